// File: rtl/br_pkg.sv
// Shared branch-type encodings and counter sizing for the branch resolution
// unit and any decode-side logic that reuses the condition comparator.
package br_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BLT  = 3'd3,
      BR_BGE  = 3'd4,
      BR_JAL  = 3'd5,
      BR_JALR = 3'd6,
      BR_RSVD = 3'd7
   } br_type_e;

   localparam int TAKEN_CNT_W = 8;

   // Unconditional jumps always redirect; everything else needs the comparator.
   function automatic logic br_is_jump(input br_type_e t);
      return (t == BR_JAL) || (t == BR_JALR);
   endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Decode-to-execute branch fields in, redirect/flush/perf outputs back out.
// The dut modport is the execute-side view; tb/drv drives decode and stall.
interface branch_resolve_if
   import br_pkg::*;
#(
   parameter int XLEN = 5,
   parameter int DLEN = 8
);
   logic                   D_valid;
   logic [2:0]             D_br_type;
   logic [XLEN-1:0]        D_pc;
   logic [XLEN-1:0]        D_imm;
   logic [DLEN-1:0]        D_rs1;
   logic [DLEN-1:0]        D_rs2;
   logic                   stall;
   logic                   EX_taken;
   logic [XLEN-1:0]        EX_alt_pc;
   logic [XLEN-1:0]        EX_link;
   logic                   flush_D;
   logic [TAKEN_CNT_W-1:0] taken_count;

   modport dut (
      input  D_valid, D_br_type, D_pc, D_imm, D_rs1, D_rs2, stall,
      output EX_taken, EX_alt_pc, EX_link, flush_D, taken_count
   );

   modport drv (
      output D_valid, D_br_type, D_pc, D_imm, D_rs1, D_rs2, stall,
      input  EX_taken, EX_alt_pc, EX_link, flush_D, taken_count
   );
endinterface

// File: rtl/br_cond.sv
// Combinational branch condition: equality and signed magnitude compare of
// the two operands selected by branch type; reserved type behaves as NONE.
module br_cond
   import br_pkg::*;
#(
   parameter int DLEN = 8
) (
   input  br_type_e        br_type,
   input  logic [DLEN-1:0] rs1,
   input  logic [DLEN-1:0] rs2,
   output logic            cond
);

   logic eq;
   logic lt;

   assign eq = (rs1 == rs2);
   assign lt = ($signed(rs1) < $signed(rs2));

   always_comb begin
      cond = 1'b0;
      case (br_type)
         BR_BEQ:  cond = eq;
         BR_BNE:  cond = ~eq;
         BR_BLT:  cond = lt;
         BR_BGE:  cond = ~lt;
         default: cond = br_is_jump(br_type);
      endcase
   end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: ID/EX register, one-shot redirect, target/link adders, taken counter.
// Redirect appears the cycle after the branch loads; stall holds the register and suppresses repeats.
module branch_resolve
   import br_pkg::*;
#(
   parameter int XLEN    = 5,
   parameter int DLEN    = 8,
   parameter int PC_STEP = 1
) (
   input  logic           clk,
   input  logic           rst,
   branch_resolve_if.dut  bif
);

   localparam logic [XLEN-1:0]        STEP    = PC_STEP[XLEN-1:0];
   localparam logic [TAKEN_CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic            valid;
      br_type_e        br_type;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [DLEN-1:0] rs1;
      logic [DLEN-1:0] rs2;
   } idex_t;

   idex_t                  idex_q, idex_d;
   logic                   fired_q, fired_d;
   logic [TAKEN_CNT_W-1:0] cnt_q, cnt_d;

   logic                   cond;
   logic                   taken;
   logic [XLEN-1:0]        base;

   br_cond #(.DLEN(DLEN)) u_cond (
      .br_type (idex_q.br_type),
      .rs1     (idex_q.rs1),
      .rs2     (idex_q.rs2),
      .cond    (cond)
   );

   // Purely from registered state, so fetch never sees a decode-side path.
   assign taken = idex_q.valid & cond & ~fired_q;

   assign base = (idex_q.br_type == BR_JALR) ? idex_q.rs1[XLEN-1:0] : idex_q.pc;

   always_comb begin
      idex_d  = idex_q;
      fired_d = fired_q;
      cnt_d   = cnt_q;

      if (bif.stall) begin
         fired_d = fired_q | taken;
      end else if (taken) begin
         // Bubble squashes the wrong-path instruction sitting in decode.
         idex_d  = '0;
         fired_d = 1'b0;
      end else begin
         idex_d.valid   = bif.D_valid;
         idex_d.br_type = br_type_e'(bif.D_br_type);
         idex_d.pc      = bif.D_pc;
         idex_d.imm     = bif.D_imm;
         idex_d.rs1     = bif.D_rs1;
         idex_d.rs2     = bif.D_rs2;
         fired_d        = 1'b0;
      end

      if (taken && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idex_q  <= '0;
         fired_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         idex_q  <= idex_d;
         fired_q <= fired_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bif.EX_taken    = taken;
   assign bif.flush_D     = taken;
   assign bif.EX_alt_pc   = base + idex_q.imm;
   assign bif.EX_link     = idex_q.pc + STEP;
   assign bif.taken_count = cnt_q;

endmodule
